// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVERFLOW_EN.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_add_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// out_overflow exists only when SERIAL_ADD_OVERFLOW_EN is defined.
interface serial_add_if #(
    parameter int WIDTH = serial_add_pkg::DEFAULT_WIDTH
) ();
    import serial_add_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_carry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
`ifdef SERIAL_ADD_OVERFLOW_EN
    logic             out_overflow;
`endif

    modport master (
`ifdef SERIAL_ADD_OVERFLOW_EN
        input  out_overflow,
`endif
        output in_valid, in_a, in_b, in_carry, out_ready,
        input  in_ready, out_valid, out_sum, out_carry
    );

    modport slave (
`ifdef SERIAL_ADD_OVERFLOW_EN
        output out_overflow,
`endif
        input  in_valid, in_a, in_b, in_carry, out_ready,
        output in_ready, out_valid, out_sum, out_carry
    );

endinterface

// File: rtl/serial_fa_cell.sv
// Combinational one-bit full adder used as the single serial datapath cell.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: operands enter over a handshake, are summed LSB-first one bit
// per clock, and the result leaves over a second handshake. SERIAL_ADD_OVERFLOW_EN adds out_overflow.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic        clk,
    input logic        rst,
    serial_add_if.slave bus
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_sum_r;
    logic             out_carry_r;
`ifdef SERIAL_ADD_OVERFLOW_EN
    logic             out_overflow_r;
`endif

    logic             s_s;
    logic             cout_s;
    logic             last_s;
    logic [WIDTH-1:0] sum_nxt_s;

    serial_fa_cell u_fa (
        .a    (a_r[0]),
        .b    (b_r[0]),
        .cin  (carry_r),
        .s    (s_s),
        .cout (cout_s)
    );

    // Next sum image: new bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    always_comb begin
        last_s               = (cnt_r == CW'(WIDTH - 1));
        sum_nxt_s            = sum_r >> 1'b1;
        sum_nxt_s[WIDTH-1]   = s_s;
    end

    // Control FSM, serial datapath registers and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            a_r            <= '0;
            b_r            <= '0;
            sum_r          <= '0;
            carry_r        <= 1'b0;
            cnt_r          <= '0;
            out_valid_r    <= 1'b0;
            out_sum_r      <= '0;
            out_carry_r    <= 1'b0;
`ifdef SERIAL_ADD_OVERFLOW_EN
            out_overflow_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r     <= bus.in_a;
                        b_r     <= bus.in_b;
                        carry_r <= bus.in_carry;
                        cnt_r   <= '0;
                        sum_r   <= '0;
                        state_r <= ADD;
                    end
                end
                ADD: begin
                    a_r     <= a_r >> 1'b1;
                    b_r     <= b_r >> 1'b1;
                    sum_r   <= sum_nxt_s;
                    carry_r <= cout_s;
                    if (last_s) begin
                        // Counter is held here so it never wraps; the next load clears it.
                        state_r        <= DONE;
                        out_valid_r    <= 1'b1;
                        out_sum_r      <= sum_nxt_s;
                        out_carry_r    <= cout_s;
`ifdef SERIAL_ADD_OVERFLOW_EN
                        out_overflow_r <= carry_r ^ cout_s;
`endif
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready     = (state_r == IDLE);
    assign bus.out_valid    = out_valid_r;
    assign bus.out_sum      = out_sum_r;
    assign bus.out_carry    = out_carry_r;
`ifdef SERIAL_ADD_OVERFLOW_EN
    assign bus.out_overflow = out_overflow_r;
`endif

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder datapath controller. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then adds them LSB-first through a single registered full-adder cell, one bit per clock. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It sits directly downstream of the operand-producing logic and replaces a WIDTH-wide ripple chain of full adders where area matters more than latency.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..32.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A, unsigned (two's complement when overflow is enabled).
- in_b  input  WIDTH  operand B.
- in_carry  input  1  carry-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  sum, modulo 2^WIDTH.
- out_carry  output  1  carry-out of the MSB.
- out_overflow  output  1  signed overflow flag; present only with SERIAL_ADD_OVERFLOW_EN.

## Operation
- The FSM has three states: IDLE, ADD and DONE.
- IDLE: in_ready=1.
  - On in_valid&in_ready, load in_a and in_b into shift registers, load in_carry into the carry register, clear the bit counter and the sum shift register, and go to ADD.
- ADD: each cycle, the cell computes s = a0^b0^c and c' = majority(a0,b0,c).
  - Shift a and b right by one.
  - Shift s into the sum register MSB (sum shifts right).
  - Register c' as the carry.
  - Increment the counter.
  - When the counter equals WIDTH-1, go to DONE after this cycle.
- DONE: out_valid=1, and out_sum, out_carry and out_overflow are held stable.
  - On out_ready, go to IDLE.
- The counter width is $clog2(WIDTH) with a minimum of 1. It never wraps: it is cleared on every load.
- in_ready=0 in ADD and DONE. in_valid in those states is ignored, with no queuing.
- Reset values:
  - state=IDLE, in_ready=1 (combinational from state).
  - out_valid=0, out_sum=0, out_carry=0, out_overflow=0.
  - Counter and all shift registers = 0.
- Reset mid-operation (ADD or DONE) aborts the operation. The result is discarded, and nothing is emitted after reset deasserts.
- WIDTH=1: ADD lasts exactly one cycle.

## Timing
- Input handshake at edge T.
- ADD occupies edges T+1..T+WIDTH.
- out_valid rises after edge T+WIDTH and is high during cycle T+WIDTH+1.
- Best-case latency is WIDTH+1 cycles from acceptance to out_valid.
- If out_ready is high when out_valid rises, the handshake completes at that edge. IDLE follows, with in_ready=1 in the next cycle.
- Peak throughput is one add per WIDTH+2 cycles.
- Backpressure: while out_ready=0, DONE holds indefinitely and outputs do not change.
- There is no combinational path from in_valid or out_ready to any output except through state.

## Configuration
- SERIAL_ADD_OVERFLOW_EN defined:
  - Adds the out_overflow port and a one-bit register capturing carry-into-MSB XOR carry-out-of-MSB during the last ADD cycle.
  - out_overflow is valid with out_valid.
- Undefined: the port and the register are absent, and all other behaviour is identical.

## Structure
- Shared package serial_add_pkg holds:
  - the state enum typedef (IDLE, ADD, DONE);
  - the default WIDTH constant;
  - a function returning the counter width.
- One sub-module is natural: serial_fa_cell, a combinational one-bit full adder with inputs a, b, cin and outputs s, cout. It is instantiated once. The carry flop stays in serial_add_ctrl.

## Test plan
- WIDTH=8, in_a=0x0F, in_b=0x01, in_carry=0, out_ready=1 -> out_valid 9 cycles after acceptance; out_sum=0x10, out_carry=0; in_ready high the cycle after the output handshake.
- in_a=0xFF, in_b=0x01, in_carry=0 -> out_sum=0x00, out_carry=1, out_overflow=0. Then in_a=0x7F, in_b=0x01 -> out_sum=0x80, out_carry=0, out_overflow=1.
- in_a=0xAA, in_b=0x55, in_carry=1 -> out_sum=0x00, out_carry=1. Hold out_ready=0 for 20 cycles -> out_valid, out_sum and out_carry stay stable; a new in_valid offered meanwhile is not accepted (in_ready=0).
- Assert rst 3 cycles into ADD, release, hold in_valid=0 -> out_valid never rises and all outputs read 0. A subsequent 0x03+0x04 -> out_sum=0x07.
- WIDTH=1 build, in_a=1, in_b=1, in_carry=1 -> out_valid 2 cycles after acceptance; out_sum=1, out_carry=1.
- Back-to-back random operands with out_ready=1 (500 ops, WIDTH=8 and 32) -> every result matches {out_carry,out_sum} = in_a+in_b+in_carry, and accepts are spaced exactly WIDTH+2 cycles apart.
